// File: rtl/mhd_pkg.sv
// Shared constants, state encodings and helpers for the MHD error injector.
package mhd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_PICK = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int WIDTH_DEF = 18;
  localparam int MHD_DEF   = 6;
  localparam int PW_DEF    = $clog2(WIDTH_DEF);
  localparam int KW_DEF    = $clog2(MHD_DEF + 1) + 1;

  function automatic int sat_k(int k, int mhd);
    return (k > mhd) ? mhd : k;
  endfunction

endpackage

// File: rtl/mhd_lfsr.sv
// Right-shifting Galois LFSR; free-running, reloadable from a seed.
module mhd_lfsr
  import mhd_pkg::*;
#(
  parameter int                 LFSR_W = 16,
  parameter logic [LFSR_W-1:0]  SEED   = 16'hACE1,
  parameter logic [LFSR_W-1:0]  TAPS   = LFSR_TAPS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = {1'b0, state_q[LFSR_W-1:1]};
    if (state_q[0]) begin
      state_d = state_d ^ TAPS;
    end
    // A zero seed would lock the register up, so it maps to SEED.
    if (load) begin
      state_d = (load_val == '0) ? SEED : load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/mhd_err_inject.sv
// Flips exactly min(in_k, MHD) distinct bits of a golden word;
// positions come from the LFSR with linear probing on collisions.
module mhd_err_inject
  import mhd_pkg::*;
#(
  parameter int                 WIDTH  = 18,
  parameter int                 MHD    = 6,
  parameter int                 LFSR_W = 16,
  parameter logic [LFSR_W-1:0]  SEED   = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(MHD+1):0]     in_k,
  input  logic                       seed_load,
  input  logic [LFSR_W-1:0]          seed_value,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [WIDTH-1:0]           out_mask,
  output logic [$clog2(MHD+1)-1:0]   out_weight
);

  localparam int PW = $clog2(WIDTH);
  localparam int WW = $clog2(MHD + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WW-1:0]    k_q, k_d;
  logic [WW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] out_mask_q, out_mask_d;
  logic [WW-1:0]    out_weight_q, out_weight_d;

  logic [LFSR_W-1:0] lfsr;
  logic              seed_ld;
  logic [PW-1:0]     c;
  logic [PW-1:0]     cand;
  logic [WW-1:0]     k_sat;
  logic              unused_lfsr_hi;

  assign seed_ld = seed_load && (state_q == S_IDLE);

  mhd_lfsr #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_ld),
    .load_val (seed_value),
    .state    (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:PW];

  assign c     = lfsr[PW-1:0];
  assign cand  = ({1'b0, c} >= (PW+1)'(WIDTH)) ? c - PW'(WIDTH) : c;
  assign k_sat = WW'(sat_k(int'(in_k), MHD));

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    mask_d       = mask_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    pos_d        = pos_q;
    out_data_d   = out_data_q;
    out_mask_d   = out_mask_q;
    out_weight_d = out_weight_q;

    unique case (1'b1)
      state_q == S_IDLE: begin
        if (in_valid && !seed_load) begin
          data_d  = in_data;
          k_d     = k_sat;
          mask_d  = '0;
          cnt_d   = '0;
          pos_d   = cand;
          state_d = (k_sat == '0) ? S_DONE : S_PICK;
        end
      end
      state_q == S_PICK: begin
        if (!mask_q[pos_q]) begin
          mask_d[pos_q] = 1'b1;
          cnt_d         = cnt_q + WW'(1);
          pos_d         = cand;
          if (cnt_q + WW'(1) == k_q) begin
            state_d = S_DONE;
          end
        end else begin
          pos_d = (pos_q == PW'(WIDTH - 1)) ? '0 : pos_q + PW'(1);
        end
      end
      state_q == S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are captured once on entry to DONE and held there.
    if (state_d == S_DONE && state_q != S_DONE) begin
      out_data_d   = data_d ^ mask_d;
      out_mask_d   = mask_d;
      out_weight_d = cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      data_q       <= '0;
      mask_q       <= '0;
      k_q          <= '0;
      cnt_q        <= '0;
      pos_q        <= '0;
      out_data_q   <= '0;
      out_mask_q   <= '0;
      out_weight_q <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      pos_q        <= pos_d;
      out_data_q   <= out_data_d;
      out_mask_q   <= out_mask_d;
      out_weight_q <= out_weight_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_data   = out_data_q;
  assign out_mask   = out_mask_q;
  assign out_weight = out_weight_q;

endmodule
